// File: rtl/parser_collect_segs.sv
// Header-segment collector: packs the first C_NUM_SEGS beats of each AXI-Stream packet
// into one wide word with first-beat tuser and an early VLAN ID, then hands it off on valid/ready.
module parser_collect_segs #(
    parameter int C_AXIS_DATA_WIDTH  = 256,
    parameter int C_AXIS_TUSER_WIDTH = 128,
    parameter int C_NUM_SEGS         = 4,
    parameter int C_VLAN_OFFSET      = 116
) (
    input  logic                                       axis_clk,
    input  logic                                       aresetn,
    input  logic [C_AXIS_DATA_WIDTH-1:0]               s_axis_tdata,
    input  logic [C_AXIS_TUSER_WIDTH-1:0]              s_axis_tuser,
    input  logic [C_AXIS_DATA_WIDTH/8-1:0]             s_axis_tkeep,
    input  logic                                       s_axis_tvalid,
    input  logic                                       s_axis_tlast,
    output logic                                       s_axis_tready,
    input  logic                                       segs_ready,
    output logic [C_NUM_SEGS*C_AXIS_DATA_WIDTH-1:0]    tdata_segs,
    output logic [C_AXIS_TUSER_WIDTH-1:0]              tuser_1st,
    output logic [$clog2(C_NUM_SEGS+1)-1:0]            segs_num,
    output logic [C_AXIS_DATA_WIDTH/8-1:0]             last_tkeep,
    output logic                                       segs_trunc,
    output logic                                       segs_valid,
    output logic [11:0]                                vlan,
    output logic                                       vlan_valid,
    output logic [1:0]                                 dbg_state
);

    localparam int W  = C_AXIS_DATA_WIDTH;
    localparam int UW = C_AXIS_TUSER_WIDTH;
    localparam int KW = C_AXIS_DATA_WIDTH / 8;
    localparam int SW = $clog2(C_NUM_SEGS + 1);

    // Handshake: a beat moves on s_axis when s_axis_tvalid && s_axis_tready at a rising
    // axis_clk edge; the segment bundle moves when segs_valid && segs_ready, and segs_* hold
    // steady while segs_valid is high and segs_ready is low.

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DRAIN   = 2'd2,
        OUTPUT  = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [C_NUM_SEGS*W-1:0] segs_q, segs_d;
    logic [UW-1:0]       tuser_q, tuser_d;
    logic [SW-1:0]       segs_num_q, segs_num_d;
    logic [KW-1:0]       last_tkeep_q, last_tkeep_d;
    logic                trunc_q, trunc_d;
    logic                segs_valid_q, segs_valid_d;
    logic [11:0]         vlan_q, vlan_d;
    logic                vlan_valid_q, vlan_valid_d;
    logic                beat_acc;

    assign s_axis_tready = aresetn && (state_q != OUTPUT);
    assign beat_acc      = s_axis_tvalid && s_axis_tready;

    always_comb begin
        state_d      = state_q;
        segs_d       = segs_q;
        tuser_d      = tuser_q;
        segs_num_d   = segs_num_q;
        last_tkeep_d = last_tkeep_q;
        trunc_d      = trunc_q;
        vlan_d       = vlan_q;
        vlan_valid_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (beat_acc) begin
                    // Clearing the unused segments keeps short packets free of stale data
                    segs_d        = '0;
                    segs_d[0 +: W] = s_axis_tdata;
                    tuser_d       = s_axis_tuser;
                    vlan_d        = s_axis_tdata[C_VLAN_OFFSET +: 12];
                    vlan_valid_d  = 1'b1;
                    segs_num_d    = SW'(1);
                    last_tkeep_d  = s_axis_tkeep;
                    trunc_d       = 1'b0;
                    if (s_axis_tlast) begin
                        state_d = OUTPUT;
                    end else if (C_NUM_SEGS == 1) begin
                        state_d = DRAIN;
                        trunc_d = 1'b1;
                    end else begin
                        state_d = COLLECT;
                    end
                end
            end
            COLLECT: begin
                if (beat_acc) begin
                    for (int i = 0; i < C_NUM_SEGS; i++) begin
                        if (segs_num_q == SW'(i)) segs_d[i*W +: W] = s_axis_tdata;
                    end
                    segs_num_d   = segs_num_q + SW'(1);
                    last_tkeep_d = s_axis_tkeep;
                    if (s_axis_tlast) begin
                        state_d = OUTPUT;
                    end else if (segs_num_d == SW'(C_NUM_SEGS)) begin
                        state_d = DRAIN;
                        trunc_d = 1'b1;
                    end
                end
            end
            DRAIN: begin
                if (beat_acc && s_axis_tlast) state_d = OUTPUT;
            end
            OUTPUT: begin
                if (segs_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        segs_valid_d = (state_d == OUTPUT);
    end

    always_ff @(posedge axis_clk) begin
        if (!aresetn) begin
            state_q      <= IDLE;
            segs_q       <= '0;
            tuser_q      <= '0;
            segs_num_q   <= '0;
            last_tkeep_q <= '0;
            trunc_q      <= 1'b0;
            segs_valid_q <= 1'b0;
            vlan_q       <= '0;
            vlan_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            segs_q       <= segs_d;
            tuser_q      <= tuser_d;
            segs_num_q   <= segs_num_d;
            last_tkeep_q <= last_tkeep_d;
            trunc_q      <= trunc_d;
            segs_valid_q <= segs_valid_d;
            vlan_q       <= vlan_d;
            vlan_valid_q <= vlan_valid_d;
        end
    end

    assign tdata_segs = segs_q;
    assign tuser_1st  = tuser_q;
    assign segs_num   = segs_num_q;
    assign last_tkeep = last_tkeep_q;
    assign segs_trunc = trunc_q;
    assign segs_valid = segs_valid_q;
    assign vlan       = vlan_q;
    assign vlan_valid = vlan_valid_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_parser_collect_segs.sv
// Self-checking bench for parser_collect_segs: table-driven packets, hand-written
// backpressure/reset sequences and randomized traffic against a packet-level reference model.
module tb_parser_collect_segs;

    localparam int W  = 256;
    localparam int UW = 128;
    localparam int KW = 32;
    localparam int NS = 4;
    localparam int SW = 3;
    localparam int VO = 116;

    typedef struct packed {
        logic [NS*W-1:0] segs;
        logic [UW-1:0]   tuser;
        logic [SW-1:0]   num;
        logic [KW-1:0]   keep;
        logic            trunc;
    } res_t;

    typedef struct {
        int          nbeats;
        int          gap;
        int          exp_num;
        logic        exp_trunc;
        bit          fix_keep;
        logic [KW-1:0] keep;
    } vec_t;

    // clock / reset
    logic axis_clk = 1'b0;
    always #5 axis_clk = ~axis_clk;
    logic aresetn;

    logic [W-1:0]    s_axis_tdata;
    logic [UW-1:0]   s_axis_tuser;
    logic [KW-1:0]   s_axis_tkeep;
    logic            s_axis_tvalid;
    logic            s_axis_tlast;
    logic            s_axis_tready;
    logic            segs_ready;
    logic [NS*W-1:0] tdata_segs;
    logic [UW-1:0]   tuser_1st;
    logic [SW-1:0]   segs_num;
    logic [KW-1:0]   last_tkeep;
    logic            segs_trunc;
    logic            segs_valid;
    logic [11:0]     vlan;
    logic            vlan_valid;
    logic [1:0]      dbg_state;

    parser_collect_segs #(
        .C_AXIS_DATA_WIDTH (W),
        .C_AXIS_TUSER_WIDTH(UW),
        .C_NUM_SEGS        (NS),
        .C_VLAN_OFFSET     (VO)
    ) dut (
        .axis_clk     (axis_clk),
        .aresetn      (aresetn),
        .s_axis_tdata (s_axis_tdata),
        .s_axis_tuser (s_axis_tuser),
        .s_axis_tkeep (s_axis_tkeep),
        .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tlast (s_axis_tlast),
        .s_axis_tready(s_axis_tready),
        .segs_ready   (segs_ready),
        .tdata_segs   (tdata_segs),
        .tuser_1st    (tuser_1st),
        .segs_num     (segs_num),
        .last_tkeep   (last_tkeep),
        .segs_trunc   (segs_trunc),
        .segs_valid   (segs_valid),
        .vlan         (vlan),
        .vlan_valid   (vlan_valid),
        .dbg_state    (dbg_state)
    );

    int   checks = 0;
    int   errors = 0;
    res_t exp_q[$];
    logic [11:0] vlan_exp_q[$];

    logic [W-1:0]  pkt_data[16];
    logic [UW-1:0] pkt_user[16];
    logic [KW-1:0] pkt_keep[16];
    int            pkt_n;
    res_t          last_res;
    logic          vlan_due = 1'b0;
    logic          rand_on = 1'b0;

    task automatic check_eq(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: a packet keeps its first NS beats, tuser of beat 0,
    // tkeep of the last kept beat, and is flagged truncated if longer than NS.
    function automatic res_t model_result();
        res_t r;
        int   k;
        k = (pkt_n < NS) ? pkt_n : NS;
        r.segs = '0;
        for (int i = 0; i < k; i++) r.segs[i*W +: W] = pkt_data[i];
        r.tuser = pkt_user[0];
        r.num   = SW'(k);
        r.keep  = pkt_keep[k-1];
        r.trunc = (pkt_n > NS);
        return r;
    endfunction

    task automatic compare_res(input string tag, input res_t e);
        for (int i = 0; i < NS; i++)
            check_eq($sformatf("%s_seg%0d", tag, i), tdata_segs[i*W +: W], e.segs[i*W +: W]);
        check_eq({tag, "_tuser"}, W'(tuser_1st), W'(e.tuser));
        check_eq({tag, "_num"}, W'(segs_num), W'(e.num));
        check_eq({tag, "_keep"}, W'(last_tkeep), W'(e.keep));
        check_eq({tag, "_trunc"}, W'(segs_trunc), W'(e.trunc));
    endtask

    task automatic check_all_zero(input string tag);
        for (int i = 0; i < NS; i++)
            check_eq($sformatf("%s_seg%0d", tag, i), tdata_segs[i*W +: W], '0);
        check_eq({tag, "_tuser"}, W'(tuser_1st), '0);
        check_eq({tag, "_num"}, W'(segs_num), '0);
        check_eq({tag, "_keep"}, W'(last_tkeep), '0);
        check_eq({tag, "_trunc"}, W'(segs_trunc), '0);
        check_eq({tag, "_valid"}, W'(segs_valid), '0);
        check_eq({tag, "_vlan"}, W'(vlan), '0);
        check_eq({tag, "_vlan_valid"}, W'(vlan_valid), '0);
        check_eq({tag, "_tready"}, W'(s_axis_tready), '0);
    endtask

    // scoreboard / monitor
    always @(negedge axis_clk) begin
        if (!aresetn) begin
            vlan_due = 1'b0;
        end else begin
            check_eq("vlan_valid_timing", W'(vlan_valid), W'(vlan_due));
            vlan_due = 1'b0;
            if (vlan_valid) begin
                if (vlan_exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL vlan_unexpected: got %0h expected no pulse", vlan);
                end else begin
                    check_eq("vlan", W'(vlan), W'(vlan_exp_q.pop_front()));
                end
            end
            if (segs_valid) begin
                checks++;
                if (segs_num == 0 || segs_num > NS) begin
                    errors++;
                    $display("FAIL segs_num_range: got %0d expected 1..%0d", segs_num, NS);
                end
            end
            if (segs_valid && segs_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL segs_unexpected: got segs_valid=1 expected no output");
                end else begin
                    compare_res("out", exp_q.pop_front());
                end
            end
        end
    end

    // drivers
    task automatic gen_packet(input int n, input bit fix_keep, input logic [KW-1:0] keep,
                              input bit push_res);
        pkt_n = n;
        for (int i = 0; i < n; i++) begin
            for (int j = 0; j < W/32; j++) pkt_data[i][j*32 +: 32] = $urandom;
            for (int j = 0; j < UW/32; j++) pkt_user[i][j*32 +: 32] = $urandom;
            pkt_keep[i] = $urandom;
        end
        if (fix_keep) pkt_keep[n-1] = keep;
        last_res = model_result();
        vlan_exp_q.push_back(pkt_data[0][VO +: 12]);
        if (push_res) exp_q.push_back(last_res);
    endtask

    task automatic drive_beat(input logic [W-1:0] d, input logic [UW-1:0] u, input logic [KW-1:0] k,
                              input logic l, output int waits);
        s_axis_tdata  = d;
        s_axis_tuser  = u;
        s_axis_tkeep  = k;
        s_axis_tlast  = l;
        s_axis_tvalid = 1'b1;
        waits = 0;
        @(negedge axis_clk);
        while (!s_axis_tready && waits < 200) begin
            @(negedge axis_clk);
            waits++;
        end
        if (!s_axis_tready) begin
            checks++;
            errors++;
            $display("FAIL tready_timeout: got tready=0 expected 1 within 200 cycles");
        end
        @(posedge axis_clk);
        #1 s_axis_tvalid = 1'b0;
    endtask

    task automatic drive_packet(input int gap, input int nb, output int w0);
        int w;
        int cnt;
        cnt = (nb < pkt_n) ? nb : pkt_n;
        w0 = 0;
        for (int i = 0; i < cnt; i++) begin
            if (i > 0 && gap > 0) begin
                repeat (gap) @(posedge axis_clk);
                #1;
            end
            drive_beat(pkt_data[i], pkt_user[i], pkt_keep[i], (i == pkt_n - 1), w);
            if (i == 0) begin
                w0 = w;
                vlan_due = 1'b1;
            end else begin
                check_eq("tready_mid_packet_waits", W'(w), '0);
            end
        end
    endtask

    vec_t vecs[7];

    initial begin
        int   w0;
        res_t e1;

        vecs[0] = '{2, 0, 2, 1'b0, 1'b0, 32'h0};
        vecs[1] = '{1, 0, 1, 1'b0, 1'b1, 32'h0000FFFF};
        vecs[2] = '{7, 0, 4, 1'b1, 1'b0, 32'h0};
        vecs[3] = '{4, 0, 4, 1'b0, 1'b1, 32'h00FF00FF};
        vecs[4] = '{3, 3, 3, 1'b0, 1'b0, 32'h0};
        vecs[5] = '{3, 0, 3, 1'b0, 1'b1, 32'h0000000F};
        vecs[6] = '{5, 1, 4, 1'b1, 1'b0, 32'h0};

        aresetn       = 1'b0;
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        s_axis_tdata  = '0;
        s_axis_tuser  = '0;
        s_axis_tkeep  = '0;
        segs_ready    = 1'b1;
        repeat (3) @(posedge axis_clk);
        @(negedge axis_clk);
        check_all_zero("reset");
        @(posedge axis_clk);
        #1 aresetn = 1'b1;

        // table-driven packets
        for (int r = 0; r < 7; r++) begin
            gen_packet(vecs[r].nbeats, vecs[r].fix_keep, vecs[r].keep, 1'b1);
            drive_packet(vecs[r].gap, 99, w0);
            @(negedge axis_clk);
            check_eq("segs_valid_after_tlast", W'(segs_valid), W'(1));
            check_eq("segs_num_row", W'(segs_num), W'(vecs[r].exp_num));
            check_eq("segs_trunc_row", W'(segs_trunc), W'(vecs[r].exp_trunc));
            if (vecs[r].fix_keep) check_eq("last_tkeep_row", W'(last_tkeep), W'(vecs[r].keep));
        end
        @(posedge axis_clk);
        #1;

        // backpressure: hold a 4-beat result for 10 cycles with the next packet waiting
        segs_ready = 1'b0;
        gen_packet(4, 1'b0, '0, 1'b1);
        e1 = last_res;
        drive_packet(0, 99, w0);
        gen_packet(1, 1'b0, '0, 1'b1);
        s_axis_tdata  = pkt_data[0];
        s_axis_tuser  = pkt_user[0];
        s_axis_tkeep  = pkt_keep[0];
        s_axis_tlast  = 1'b1;
        s_axis_tvalid = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge axis_clk);
            check_eq("hold_tready", W'(s_axis_tready), '0);
            check_eq("hold_valid", W'(segs_valid), W'(1));
            compare_res("hold", e1);
        end
        @(posedge axis_clk);
        #1 segs_ready = 1'b1;
        drive_packet(0, 99, w0);
        check_eq("accept_after_idle_waits", W'(w0), W'(1));
        @(negedge axis_clk);
        check_eq("one_beat_valid", W'(segs_valid), W'(1));
        check_eq("one_beat_num", W'(segs_num), W'(1));
        @(posedge axis_clk);
        #1;

        // reset mid-packet drops the partial result
        gen_packet(4, 1'b0, '0, 1'b0);
        drive_packet(0, 2, w0);
        aresetn = 1'b0;
        @(posedge axis_clk);
        @(negedge axis_clk);
        check_all_zero("abort");
        @(posedge axis_clk);
        #1 aresetn = 1'b1;
        gen_packet(2, 1'b0, '0, 1'b1);
        drive_packet(0, 99, w0);
        @(negedge axis_clk);
        check_eq("after_abort_num", W'(segs_num), W'(2));
        check_eq("after_abort_seg2", tdata_segs[2*W +: W], '0);
        check_eq("after_abort_seg3", tdata_segs[3*W +: W], '0);
        @(posedge axis_clk);
        #1;

        // randomized traffic with random downstream backpressure
        rand_on = 1'b1;
        fork
            begin
                for (int p = 0; p < 40; p++) begin
                    gen_packet($urandom_range(1, 8), 1'b0, '0, 1'b1);
                    drive_packet($urandom_range(0, 2), 99, w0);
                    repeat ($urandom_range(0, 3)) @(posedge axis_clk);
                    #1;
                end
                rand_on = 1'b0;
            end
            begin
                while (rand_on) begin
                    @(posedge axis_clk);
                    #1 segs_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join

        @(posedge axis_clk);
        #1 segs_ready = 1'b1;
        for (int g = 0; g < 100 && (exp_q.size() != 0 || vlan_exp_q.size() != 0); g++)
            @(negedge axis_clk);
        check_eq("pending_results", W'(exp_q.size()), '0);
        check_eq("pending_vlans", W'(vlan_exp_q.size()), '0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
